iob_ram_2p_be: RTL and testbench
================================

IOB_RAM_2P_BE -- requirements
Module: iob_ram_2p_be

Interface
REQ-001 SHALL have parameter DATA_W, default 32: data width in bits; must be a multiple of 8, minimum 8.
REQ-002 SHALL have parameter ADDR_W, default 4: address width; depth = 2**ADDR_W words.
REQ-003 SHALL have parameter READ_LAT, default 1: read latency in cycles; legal values are 1 and 2.
REQ-004 SHALL have parameter RDW_MODE, default 0: same-address read-during-write policy; 0 = READ_FIRST, 1 = WRITE_FIRST.
REQ-005 SHALL have port clk  input  1  clock; all state is updated on its rising edge.
REQ-006 SHALL have port arst_n  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port w_en  input  1  write request.
REQ-008 SHALL have port w_strb  input  DATA_W/8  byte write enables; bit b covers w_data[8b+7:8b].
REQ-009 SHALL have port w_addr  input  ADDR_W  write address.
REQ-010 SHALL have port w_data  input  DATA_W  write data.
REQ-011 SHALL have port r_en  input  1  read request.
REQ-012 SHALL have port r_addr  input  ADDR_W  read address.
REQ-013 SHALL have port r_data  output  DATA_W  registered read data.
REQ-014 SHALL have port r_valid  output  1  one-cycle pulse marking new r_data.

Function
REQ-015 SHALL, at each clk edge with w_en=1, write byte b of w_data to mem[w_addr] only where w_strb[b]=1; all other bytes SHALL be unchanged.
REQ-016 SHALL leave memory unchanged when w_en=1 and w_strb is all zeros.
REQ-017 SHALL ignore w_strb, w_addr and w_data when w_en=0.
REQ-018 SHALL, for a read sampled at edge k (r_en=1), present the word on r_data and assert r_valid=1 after edge k+READ_LAT-1.
REQ-019 SHALL assert r_valid for exactly one cycle per accepted read; back-to-back reads SHALL give one r_valid per cycle, with full throughput and in order.
REQ-020 SHALL hold r_data at its last value whenever no read completes; r_en=0 SHALL NOT change r_data.
REQ-021 SHALL, when READ_LAT=2, hold the read address and the first-stage data in internal registers so that the read pipeline advances every cycle, independent of r_en.
REQ-022 SHALL, when w_en=1, r_en=1 and w_addr==r_addr at the same edge with RDW_MODE=0, return the pre-write word.
REQ-023 SHALL, in the same collision case with RDW_MODE=1, return the merged word: new bytes where w_strb=1, old bytes elsewhere.
REQ-024 SHALL apply the normal read behaviour, with no collision handling, when the write and read addresses differ on the same edge.
REQ-025 SHALL select the RDW_MODE and READ_LAT logic at elaboration time, with no runtime mode switching.

Reset
REQ-026 SHALL, while arst_n=0, immediately and asynchronously force r_data=0, r_valid=0 and all read-pipeline state to 0.
REQ-027 SHALL discard any read in flight when reset is asserted; no r_valid SHALL appear for that read after release.
REQ-028 SHALL NOT reset memory contents; the array holds its data through reset.
REQ-029 SHALL ignore w_en and r_en while arst_n=0; normal operation SHALL start at the first rising edge after arst_n is released.

Verification (DATA_W=32, ADDR_W=4)
REQ-030 SHALL cover full write then read: write 0x20+i to addresses 0..15 with w_strb=4'hF, then read 0..15 -> r_data=0x20+i; r_valid pulses after READ_LAT cycles. Run this for both READ_LAT=1 and READ_LAT=2.
REQ-031 SHALL cover the r_en=0 sweep: after reset, sweep r_addr 0..15 with r_en=0 -> r_data stays 0 and r_valid stays 0 throughout.
REQ-032 SHALL cover byte strobes: write 0xAABBCCDD to address 3, then write 0x11223344 with w_strb=4'b0101 -> reading address 3 returns 0xAA22CC44. A write with w_strb=0 leaves the word unchanged.
REQ-033 SHALL cover collisions: mem[5]=0x00000000, then on one edge write 0xFFFFFFFF with w_strb=4'b0011 while reading address 5 -> RDW_MODE=0 returns 0x00000000; RDW_MODE=1 returns 0x0000FFFF.
REQ-034 SHALL cover reset mid-read: with READ_LAT=2, issue a read, then pulse arst_n low between edges -> r_data=0 and r_valid=0 at once, no later r_valid, and a subsequent read returns the pre-reset contents.

Source files
------------

// File: rtl/iob_ram_2p_be.sv
// Simple dual-port RAM with per-byte write strobes, configurable read latency
// (1 or 2) and same-address read-during-write policy fixed at elaboration.
module iob_ram_2p_be #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 4,
    parameter int READ_LAT = 1,
    parameter int RDW_MODE = 0
) (
    input  logic                  clk,
    input  logic                  arst_n,
    input  logic                  w_en,
    input  logic [DATA_W/8-1:0]   w_strb,
    input  logic [ADDR_W-1:0]     w_addr,
    input  logic [DATA_W-1:0]     w_data,
    input  logic                  r_en,
    input  logic [ADDR_W-1:0]     r_addr,
    output logic [DATA_W-1:0]     r_data,
    output logic                  r_valid
);
    localparam int STRB_W = DATA_W / 8;
    localparam int DEPTH  = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rd_word_p0;

    function automatic logic [DATA_W-1:0] merge_bytes(
        input logic [DATA_W-1:0] old_word,
        input logic [DATA_W-1:0] new_word,
        input logic [STRB_W-1:0] strb
    );
        logic [DATA_W-1:0] res;
        res = old_word;
        for (int b = 0; b < STRB_W; b++) begin
            if (strb[b]) res[8*b +: 8] = new_word[8*b +: 8];
        end
        return res;
    endfunction

    // Array contents survive reset; writes are simply blocked while it is held.
    always_ff @(posedge clk) begin
        if (arst_n && w_en) begin
            mem[w_addr] <= merge_bytes(mem[w_addr], w_data, w_strb);
        end
    end

    // Stage p0: word seen by a read at this edge, with collision policy applied
    generate
        if (RDW_MODE == 1) begin : g_write_first
            always_comb begin
                rd_word_p0 = mem[r_addr];
                if (w_en && (w_addr == r_addr)) begin
                    rd_word_p0 = merge_bytes(mem[r_addr], w_data, w_strb);
                end
            end
        end else begin : g_read_first
            assign rd_word_p0 = mem[r_addr];
        end
    endgenerate

    generate
        if (READ_LAT == 2) begin : g_lat2
            logic              vld_p1;
            logic [DATA_W-1:0] data_p1;

            // Stage p1: captured word and its valid advance every cycle
            always_ff @(posedge clk or negedge arst_n) begin
                if (!arst_n) begin
                    vld_p1  <= 1'b0;
                    data_p1 <= '0;
                    r_valid <= 1'b0;
                    r_data  <= '0;
                end else begin
                    vld_p1  <= r_en;
                    data_p1 <= rd_word_p0;
                    r_valid <= vld_p1;
                    if (vld_p1) r_data <= data_p1;
                end
            end
        end else begin : g_lat1
            // Stage p1: output register loaded directly from the array
            always_ff @(posedge clk or negedge arst_n) begin
                if (!arst_n) begin
                    r_valid <= 1'b0;
                    r_data  <= '0;
                end else begin
                    r_valid <= r_en;
                    if (r_en) r_data <= rd_word_p0;
                end
            end
        end
    endgenerate
endmodule

// File: tb/tb_iob_ram_2p_be.sv
// Randomized and directed bench for iob_ram_2p_be: four instances cover both
// read latencies and both read-during-write policies against one memory model.
module tb_iob_ram_2p_be;
    logic        clk = 1'b0;
    logic        arst_n = 1'b1;
    logic        w_en = 1'b0;
    logic [3:0]  w_strb = '0;
    logic [3:0]  w_addr = '0;
    logic [31:0] w_data = '0;
    logic        r_en = 1'b0;
    logic [3:0]  r_addr = '0;
    logic [31:0] rd [4];
    logic        rv [4];

    int vectors = 0;
    int miscompares = 0;
    bit checking = 1'b0;

    always #5 clk = ~clk;

    // Instance i: READ_LAT = 1 for i<2 else 2; RDW_MODE = i%2
    for (genvar g = 0; g < 4; g++) begin : g_dut
        iob_ram_2p_be #(
            .DATA_W(32), .ADDR_W(4), .READ_LAT((g >= 2) ? 2 : 1), .RDW_MODE(g % 2)
        ) u_dut (
            .clk(clk), .arst_n(arst_n), .w_en(w_en), .w_strb(w_strb),
            .w_addr(w_addr), .w_data(w_data), .r_en(r_en), .r_addr(r_addr),
            .r_data(rd[g]), .r_valid(rv[g])
        );
    end

    // Behavioural model: memory array plus a list of reads with their due edge
    typedef struct {
        int          dut;
        int          due;
        logic [31:0] data;
    } pend_t;

    logic [31:0] mem_m [16];
    pend_t       pend [$];
    logic [31:0] exp_data [4];
    logic        exp_vld [4];
    int          cyc = 0;

    function automatic logic [31:0] apply_strb(input logic [31:0] old_w, input logic [31:0] new_w,
                                               input logic [3:0] strb);
        logic [31:0] r;
        r = old_w;
        for (int b = 0; b < 4; b++) if (strb[b]) r[8*b +: 8] = new_w[8*b +: 8];
        return r;
    endfunction

    task automatic model_reset();
        pend.delete();
        for (int i = 0; i < 4; i++) begin
            exp_data[i] = '0;
            exp_vld[i]  = 1'b0;
        end
    endtask

    task automatic model_edge();
        pend_t keep [$];
        logic [31:0] d;
        if (!arst_n) return;
        cyc++;
        for (int i = 0; i < 4; i++) exp_vld[i] = 1'b0;
        if (r_en) begin
            for (int i = 0; i < 4; i++) begin
                d = mem_m[r_addr];
                if ((i % 2 == 1) && w_en && (w_addr == r_addr)) d = apply_strb(d, w_data, w_strb);
                pend.push_back('{dut: i, due: cyc + ((i >= 2) ? 2 : 1) - 1, data: d});
            end
        end
        foreach (pend[j]) begin
            if (pend[j].due == cyc) begin
                exp_vld[pend[j].dut]  = 1'b1;
                exp_data[pend[j].dut] = pend[j].data;
            end else begin
                keep.push_back(pend[j]);
            end
        end
        pend = keep;
        if (w_en) mem_m[w_addr] = apply_strb(mem_m[w_addr], w_data, w_strb);
    endtask

    // Compare process: every DUT output checked against the model each cycle
    always @(negedge clk) begin
        if (checking) begin
            for (int i = 0; i < 4; i++) begin
                vectors++;
                if (rv[i] !== exp_vld[i] || rd[i] !== exp_data[i]) begin
                    miscompares++;
                    $display("FAIL cycle dut%0d cyc=%0d: r_valid=%b r_data=%h, expected r_valid=%b r_data=%h",
                             i, cyc, rv[i], rd[i], exp_vld[i], exp_data[i]);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic drive(input logic we, input logic [3:0] strb, input logic [3:0] wa,
                         input logic [31:0] wd, input logic re, input logic [3:0] ra);
        w_en = we; w_strb = strb; w_addr = wa; w_data = wd; r_en = re; r_addr = ra;
        tick();
    endtask

    task automatic idle();
        drive(1'b0, 4'h0, 4'h0, 32'h0, 1'b0, 4'h0);
    endtask

    initial begin
        model_reset();
        #2 arst_n = 1'b0;
        #1 checking = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("reset_rdata%0d", i), rd[i], 32'h0);
            chk($sformatf("reset_rvalid%0d", i), {31'h0, rv[i]}, 32'h0);
        end
        // Requests during reset are ignored
        w_en = 1'b1; w_strb = 4'hF; r_en = 1'b1;
        repeat (3) @(negedge clk);
        w_en = 1'b0; r_en = 1'b0;
        arst_n = 1'b1;

        // r_en=0 sweep with junk on the write bus but w_en=0
        for (int a = 0; a < 16; a++) drive(1'b0, 4'(a), 4'(a), $urandom, 1'b0, 4'(a));
        for (int i = 0; i < 4; i++) chk($sformatf("sweep_rdata%0d", i), rd[i], 32'h0);

        // Full write then back-to-back read
        for (int a = 0; a < 16; a++) drive(1'b1, 4'hF, 4'(a), 32'h20 + a, 1'b0, 4'h0);
        for (int a = 0; a < 16; a++) begin
            drive(1'b0, 4'h0, 4'h0, 32'h0, 1'b1, 4'(a));
            if (a == 0) begin
                chk("first_read_lat1_data", rd[0], 32'h20);
                chk("first_read_lat1_valid", {31'h0, rv[0]}, 32'h1);
                chk("first_read_lat2_valid", {31'h0, rv[2]}, 32'h0);
            end
            if (a == 1) begin
                chk("second_read_lat1_data", rd[0], 32'h21);
                chk("first_read_lat2_data", rd[2], 32'h20);
            end
        end
        idle();
        for (int i = 0; i < 4; i++) chk($sformatf("readback_last%0d", i), rd[i], 32'h2F);

        // Byte strobes
        drive(1'b1, 4'hF, 4'd3, 32'hAABBCCDD, 1'b0, 4'h0);
        drive(1'b1, 4'b0101, 4'd3, 32'h11223344, 1'b0, 4'h0);
        drive(1'b0, 4'h0, 4'h0, 32'h0, 1'b1, 4'd3);
        idle();
        for (int i = 0; i < 4; i++) chk($sformatf("strobe%0d", i), rd[i], 32'hAA22CC44);
        drive(1'b1, 4'h0, 4'd3, 32'h0, 1'b0, 4'h0);
        drive(1'b0, 4'h0, 4'h0, 32'h0, 1'b1, 4'd3);
        idle();
        for (int i = 0; i < 4; i++) chk($sformatf("zero_strobe%0d", i), rd[i], 32'hAA22CC44);

        // Same-address read during write
        drive(1'b1, 4'hF, 4'd5, 32'h0, 1'b0, 4'h0);
        drive(1'b1, 4'b0011, 4'd5, 32'hFFFFFFFF, 1'b1, 4'd5);
        idle();
        for (int i = 0; i < 4; i++)
            chk($sformatf("collision%0d", i), rd[i], (i % 2 == 1) ? 32'h0000FFFF : 32'h0);
        drive(1'b0, 4'h0, 4'h0, 32'h0, 1'b1, 4'd5);
        idle();
        for (int i = 0; i < 4; i++) chk($sformatf("after_collision%0d", i), rd[i], 32'h0000FFFF);

        // Random traffic, addresses often narrowed to provoke collisions
        for (int n = 0; n < 600; n++) begin
            logic [3:0] wa, ra;
            wa = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(0, 2)) : 4'($urandom);
            ra = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(0, 2)) : 4'($urandom);
            drive(1'($urandom), 4'($urandom), wa, $urandom, 1'($urandom), ra);
        end
        idle();
        idle();

        // Reset pulse between edges while a latency-2 read is in flight
        drive(1'b1, 4'hF, 4'd7, 32'h12345678, 1'b0, 4'h0);
        idle();
        drive(1'b0, 4'h0, 4'h0, 32'h0, 1'b1, 4'd7);
        r_en = 1'b0;
        #2 arst_n = 1'b0;
        model_reset();
        #1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("midreset_rdata%0d", i), rd[i], 32'h0);
            chk($sformatf("midreset_rvalid%0d", i), {31'h0, rv[i]}, 32'h0);
        end
        #1 arst_n = 1'b1;
        tick();
        chk("no_stale_valid_lat2", {31'h0, rv[2]}, 32'h0);
        chk("no_stale_valid_lat2_wf", {31'h0, rv[3]}, 32'h0);
        idle();
        drive(1'b0, 4'h0, 4'h0, 32'h0, 1'b1, 4'd7);
        idle();
        for (int i = 0; i < 4; i++) chk($sformatf("post_reset_read%0d", i), rd[i], 32'h12345678);
        idle();

        checking = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete, expected completion");
        $fatal(1);
    end
endmodule
